// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch stage.
package fetch_pkg;

   localparam logic [31:0] START_ADDR_DEFAULT = 32'h0100_0000;
   localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR       = 32'h0010_0073;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, otherwise hold.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 load,
   input  logic                 flush,
   input  logic [ADDRWIDTH-1:0] pc_d,
   input  logic [DATAWIDTH-1:0] instr_d,
   output logic [ADDRWIDTH-1:0] pc_q,
   output logic [DATAWIDTH-1:0] instr_q,
   output logic                 valid_q
);

   always_ff @(posedge clk) begin
      if (flush) begin
         pc_q    <= '0;
         instr_q <= DATAWIDTH'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (load) begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, BOOT/RUN/HALT control and IF/ID register.
// Define FETCH_HALT_ON_EBREAK_EN to halt fetch after an EBREAK is fetched.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                   ADDRWIDTH  = 32,
   parameter int                   DATAWIDTH  = 32,
   parameter logic [ADDRWIDTH-1:0] START_ADDR = ADDRWIDTH'(START_ADDR_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [ADDRWIDTH-1:0] redirect_target,
   output logic [ADDRWIDTH-1:0] imem_address,
   output logic                 imem_read_write,
   input  logic [DATAWIDTH-1:0] imem_data_out,
   output logic [ADDRWIDTH-1:0] if_id_pc,
   output logic [DATAWIDTH-1:0] if_id_instr,
   output logic                 if_id_valid,
   output logic                 halted
);

   fetch_state_t         state_q;
   logic [ADDRWIDTH-1:0] pc_q;
   logic                 is_ebreak;
   logic                 ifid_load;
   logic                 ifid_flush;

`ifdef FETCH_HALT_ON_EBREAK_EN
   assign is_ebreak = (imem_data_out == DATAWIDTH'(EBREAK_INSTR));
   assign halted    = (state_q == HALT);
`else
   assign is_ebreak = 1'b0;
   assign halted    = 1'b0;
`endif

   assign imem_address    = pc_q;
   assign imem_read_write = 1'b0;

   // Reset and redirect override stall; BOOT/HALT only ever feed bubbles.
   always_comb begin
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      if (reset || redirect)
         ifid_flush = 1'b1;
      else if (!stall) begin
         if (state_q == RUN) ifid_load  = 1'b1;
         else                ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= START_ADDR;
      end else if (redirect) begin
         state_q <= RUN;
         pc_q    <= {redirect_target[ADDRWIDTH-1:2], 2'b00};
      end else if (!stall) begin
         unique case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               pc_q <= pc_q + ADDRWIDTH'(4);
               if (is_ebreak) state_q <= HALT;
            end
            HALT: state_q <= HALT;
            default: state_q <= BOOT;
         endcase
      end
   end

   if_id_reg #(
      .ADDRWIDTH(ADDRWIDTH),
      .DATAWIDTH(DATAWIDTH)
   ) u_if_id (
      .clk    (clk),
      .load   (ifid_load),
      .flush  (ifid_flush),
      .pc_d   (pc_q),
      .instr_d(imem_data_out),
      .pc_q   (if_id_pc),
      .instr_q(if_id_instr),
      .valid_q(if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control traffic vs a cycle model.
module tb_fetch_stage;

   localparam logic [31:0] START  = 32'h0100_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef FETCH_HALT_ON_EBREAK_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_address, imem_data_out, if_id_pc, if_id_instr;
   logic        imem_read_write, if_id_valid, halted;
   logic        ebk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   // Model: mode 0=boot, 1=run, 2=halt
   int          m_mode;
   logic [31:0] m_pc, m_ifpc, m_ifinstr;
   logic        m_ifv;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_target(redirect_target),
      .imem_address   (imem_address),
      .imem_read_write(imem_read_write),
      .imem_data_out  (imem_data_out),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .if_id_valid    (if_id_valid),
      .halted         (halted)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic en);
      logic [31:0] w;
      if (en && a == 32'h0100_0010) return EBREAK;
      w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      if (w == EBREAK) w = w ^ 32'h100;
      return w;
   endfunction

   always_comb imem_data_out = mem_fn(imem_address, ebk_en);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_address", imem_address, m_pc);
      chk("if_id_pc", if_id_pc, m_ifpc);
      chk("if_id_instr", if_id_instr, m_ifinstr);
      chk("if_id_valid", 32'(if_id_valid), 32'(m_ifv));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("imem_rw", 32'(imem_read_write), 32'd0);
   endtask

   task automatic bubble();
      m_ifpc = '0; m_ifinstr = NOP; m_ifv = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model, then compare #1 after the edge.
   task automatic step(input logic st, input logic rd, input logic rst, input logic [31:0] tgt);
      logic [31:0] w;
      w = mem_fn(m_pc, ebk_en);
      stall = st; redirect = rd; reset = rst; redirect_target = tgt;
      @(posedge clk);
      if (rst) begin
         m_pc = START; m_mode = 0; bubble();
      end else if (rd) begin
         m_pc = tgt & ~32'h3; m_mode = 1; bubble();
      end else if (!st) begin
         case (m_mode)
            0: begin m_mode = 1; bubble(); end
            1: begin
               m_ifpc = m_pc; m_ifinstr = w; m_ifv = 1'b1;
               m_pc = m_pc + 32'd4;
               if (HALT_EN && w == EBREAK) m_mode = 2;
            end
            default: bubble();
         endcase
      end
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] held_pc, held_instr;
      m_mode = 0; m_pc = START; bubble();

      // Reset, then four free cycles
      step(0, 0, 1, 0);
      chk("rst_addr", imem_address, START);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      step(0, 0, 0, 0);
      chk("boot_addr", imem_address, START);
      step(0, 0, 0, 0);
      chk("first_pc", if_id_pc, START);
      chk("first_valid", 32'(if_id_valid), 32'd1);
      step(0, 0, 0, 0);
      chk("addr_8", imem_address, 32'h0100_0008);

      // Stall 3 cycles at 01000008
      held_pc = if_id_pc; held_instr = if_id_instr;
      repeat (3) step(1, 0, 0, 0);
      chk("stall_addr", imem_address, 32'h0100_0008);
      chk("stall_ifpc", if_id_pc, held_pc);
      chk("stall_instr", if_id_instr, held_instr);
      step(0, 0, 0, 0);
      chk("resume_addr", imem_address, 32'h0100_000C);

      // Redirect beats stall and aligns target
      step(1, 1, 0, 32'h0100_0103);
      chk("redir_addr", imem_address, 32'h0100_0100);
      chk("redir_instr", if_id_instr, NOP);

      // PC wrap
      step(0, 1, 0, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_addr", imem_address, 32'h0000_0000);
      chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

      // EBREAK at 01000010
      ebk_en = 1'b1;
      step(0, 1, 0, START);
      repeat (5) step(0, 0, 0, 0);
      chk("ebrk_instr", if_id_instr, EBREAK);
      chk("ebrk_halted", 32'(halted), 32'(HALT_EN));
      repeat (3) step(0, 0, 0, 0);
      if (HALT_EN) chk("halt_pc", imem_address, 32'h0100_0014);
      step(0, 1, 0, START);
      chk("unhalt", 32'(halted), 32'd0);
      repeat (5) step(0, 0, 0, 0);
      step(1, 0, 1, 0);   // reset during halt (or stall)
      chk("rst_halt_addr", imem_address, START);
      step(0, 0, 0, 0);

      // Random control traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         logic        st, rd, rs;
         st = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 2))
            0: tgt = $urandom();
            1: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: tgt = 32'h0100_0000 | 32'($urandom_range(0, 31));
         endcase
         ebk_en = ($urandom_range(0, 1) == 1);
         step(st, rd, rs, tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
